mem_stage_lsu: RTL and testbench

MEM-stage consumer of the EX/MEM pipeline register: takes each valid entry via the Mready/valid handshake, performs its load or store on a request/response data-memory port, and offers the result to the MEM/WB register with Mvalid/Wready. Load data is lane-extracted and sign/zero-extended here. One outstanding access; no speculation.

---
 rtl/mem_stage_lsu_if.sv | 31 +++
 rtl/mem_stage_lsu.sv | 166 ++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_lsu_if
//  Description : Request/response data-memory port between the MEM-stage
//                load/store unit (master) and data memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_lsu_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      dreq;
    logic                      dgnt;
    logic                      dwe;
    logic [DATA_WIDTH-1:0]     daddr;
    logic [DATA_WIDTH-1:0]     dwdata;
    logic [DATA_WIDTH/8-1:0]   dwstrb;
    logic                      drvalid;
    logic [DATA_WIDTH-1:0]     drdata;
    logic                      derr;

    modport master (
        output dreq, dwe, daddr, dwdata, dwstrb,
        input  dgnt, drvalid, drdata, derr
    );

    modport slave (
        input  dreq, dwe, daddr, dwdata, dwstrb,
        output dgnt, drvalid, drdata, derr
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_lsu
//  Description : MEM-stage load/store unit. Accepts one EX/MEM entry at a
//                time, performs the access on a request/response memory port,
//                lane-extracts and extends load data, and offers the result
//                to MEM/WB. One outstanding access, misalignment trapped.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                    clk,
    input  wire logic                    resetn,
    // EX/MEM side
    input  wire logic                    in_valid,
    output logic                         Mready,
    input  wire logic                    MemReadM,
    input  wire logic                    MemWriteM,
    input  wire logic [DATA_WIDTH/8-1:0] WmaskM,
    input  wire logic [2:0]              RopcodeM,
    input  wire logic [DATA_WIDTH-1:0]   ALUResultM,
    input  wire logic [DATA_WIDTH-1:0]   WriteDataM,
    // MEM/WB side
    output logic                         Mvalid,
    input  wire logic                    Wready,
    output logic [DATA_WIDTH-1:0]        ReadDataM,
    output logic                         MemErrM,
    // data memory port
    mem_stage_lsu_if.master              dmem
);

    localparam int c_STRB_W = DATA_WIDTH / 8;
    localparam int c_OFF_W  = $clog2(c_STRB_W);
    localparam logic [c_STRB_W-1:0] c_MASK_H = {{(c_STRB_W-2){1'b0}}, 2'b11};
    localparam logic [c_STRB_W-1:0] c_MASK_W = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_is_load;
    logic [2:0]            r_ropc;
    logic [c_OFF_W-1:0]    r_off;

    logic                  w_xfer;
    logic                  w_is_mem;
    logic                  w_misaligned;
    logic [c_OFF_W-1:0]    w_off;
    logic [DATA_WIDTH-1:0] w_shift;
    logic [DATA_WIDTH-1:0] w_load_data;

    assign w_off    = ALUResultM[c_OFF_W-1:0];
    assign w_is_mem = MemReadM | MemWriteM;
    assign w_xfer   = in_valid && (r_state == S_IDLE);

    assign Mready    = (r_state == S_IDLE);
    assign Mvalid    = (r_state == S_DONE);
    assign dmem.dreq = (r_state == S_REQ);

    // Alignment check; a load takes precedence if both read and write are set.
    // Loads decode funct3[1:0]: 00 byte, 01 half, anything else is a word.
    always_comb begin
        w_misaligned = 1'b0;
        if (MemReadM) begin
            case (RopcodeM[1:0])
                2'b00:   w_misaligned = 1'b0;
                2'b01:   w_misaligned = w_off[0];
                default: w_misaligned = |w_off;
            endcase
        end else if (MemWriteM) begin
            if (WmaskM == c_MASK_H) begin
                w_misaligned = w_off[0];
            end else if (WmaskM == c_MASK_W) begin
                w_misaligned = |w_off;
            end
        end
    end

    // Response lane extraction and sign/zero extension for the latched load type.
    always_comb begin
        w_shift = dmem.drdata >> {r_off, 3'b000};
        case (r_ropc)
            3'b000:  w_load_data = {{(DATA_WIDTH-8){w_shift[7]}},   w_shift[7:0]};
            3'b001:  w_load_data = {{(DATA_WIDTH-16){w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_load_data = {{(DATA_WIDTH-8){1'b0}},         w_shift[7:0]};
            3'b101:  w_load_data = {{(DATA_WIDTH-16){1'b0}},        w_shift[15:0]};
            default: w_load_data = w_shift;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: aligned memory entries go through the bus, everything
    // else (non-memory or misaligned) completes straight away.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = (w_is_mem && !w_misaligned) ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                if (dmem.dgnt) begin
                    w_state_nxt = S_RSP;
                end
            end
            S_RSP: begin
                if (dmem.drvalid) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (Wready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request fields captured at acceptance and held through the access;
    // result captured at acceptance (error/zero) or at the response.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_is_load    <= 1'b0;
            r_ropc       <= 3'b000;
            r_off        <= '0;
            dmem.daddr   <= '0;
            dmem.dwe     <= 1'b0;
            dmem.dwdata  <= '0;
            dmem.dwstrb  <= '0;
            ReadDataM    <= '0;
            MemErrM      <= 1'b0;
        end else if (w_xfer) begin
            r_is_load    <= MemReadM;
            r_ropc       <= RopcodeM;
            r_off        <= w_off;
            dmem.daddr   <= {ALUResultM[DATA_WIDTH-1:c_OFF_W], {c_OFF_W{1'b0}}};
            dmem.dwe     <= MemWriteM && !MemReadM;
            dmem.dwdata  <= WriteDataM << {w_off, 3'b000};
            dmem.dwstrb  <= WmaskM << w_off;
            ReadDataM    <= '0;
            MemErrM      <= w_misaligned;
        end else if ((r_state == S_RSP) && dmem.drvalid) begin
            ReadDataM    <= r_is_load ? w_load_data : '0;
            MemErrM      <= dmem.derr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage_lsu
//  Description : Self-checking bench for mem_stage_lsu with a configurable
//                grant/response memory model and a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        Mready;
    logic        MemReadM;
    logic        MemWriteM;
    logic [3:0]  WmaskM;
    logic [2:0]  RopcodeM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        Mvalid;
    logic        Wready;
    logic [31:0] ReadDataM;
    logic        MemErrM;

    mem_stage_lsu_if #(.DATA_WIDTH(32)) dmem ();

    mem_stage_lsu #(.DATA_WIDTH(32)) u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .Mready     (Mready),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .WmaskM     (WmaskM),
        .RopcodeM   (RopcodeM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .Mvalid     (Mvalid),
        .Wready     (Wready),
        .ReadDataM  (ReadDataM),
        .MemErrM    (MemErrM),
        .dmem       (dmem.master)
    );

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // memory model configuration and request log
    int          cfg_gnt_wait = 0;
    int          cfg_rsp_wait = 0;
    logic [31:0] cfg_rdata    = 32'h0;
    logic        cfg_derr     = 1'b0;
    logic        stray_rsp    = 1'b0;
    int          n_grants     = 0;
    logic [31:0] log_addr, log_wdata;
    logic [3:0]  log_strb;
    logic        log_we;

    // scoreboard: {err, rdata}
    logic [32:0] sbq[$];
    int          xfer_cyc   = 0;
    int          mvalid_cyc = 0;
    logic        mv_prev    = 1'b0;
    logic        mv_seen    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: grant after cfg_gnt_wait cycles, respond cfg_rsp_wait
    // cycles after the grant cycle (at least one cycle later).
    initial begin
        int gnt_cnt;
        int rsp_cnt;
        logic pending;
        gnt_cnt = -1; rsp_cnt = 0; pending = 1'b0;
        dmem.dgnt = 1'b0; dmem.drvalid = 1'b0; dmem.drdata = '0; dmem.derr = 1'b0;
        forever begin
            @(negedge clk);
            dmem.dgnt    = 1'b0;
            dmem.drvalid = 1'b0;
            if (!resetn) begin
                gnt_cnt = -1;
                pending = 1'b0;
            end else if (stray_rsp) begin
                dmem.drvalid = 1'b1;
                dmem.drdata  = cfg_rdata;
                dmem.derr    = 1'b0;
                stray_rsp    = 1'b0;
            end else if (pending) begin
                if (rsp_cnt == 0) begin
                    dmem.drvalid = 1'b1;
                    dmem.drdata  = cfg_rdata;
                    dmem.derr    = cfg_derr;
                    pending      = 1'b0;
                end else begin
                    rsp_cnt--;
                end
            end else if (dmem.dreq) begin
                if (gnt_cnt < 0) begin
                    gnt_cnt   = cfg_gnt_wait;
                    log_addr  = dmem.daddr;
                    log_we    = dmem.dwe;
                    log_wdata = dmem.dwdata;
                    log_strb  = dmem.dwstrb;
                end else begin
                    chk("stable_daddr",  dmem.daddr,  log_addr);
                    chk("stable_dwe",    {31'h0, dmem.dwe}, {31'h0, log_we});
                    chk("stable_dwdata", dmem.dwdata, log_wdata);
                    chk("stable_dwstrb", {28'h0, dmem.dwstrb}, {28'h0, log_strb});
                    chk("busy_mready",   {31'h0, Mready}, 32'h0);
                end
                if (gnt_cnt == 0) begin
                    dmem.dgnt = 1'b1;
                    pending   = 1'b1;
                    rsp_cnt   = cfg_rsp_wait;
                    gnt_cnt   = -1;
                    n_grants++;
                end else begin
                    gnt_cnt--;
                end
            end
        end
    end

    // Result monitor: compare on each Mvalid&&Wready handshake.
    initial forever begin
        @(negedge clk);
        #2;
        if (resetn && Mvalid) begin
            if (!mv_prev) mvalid_cyc = cyc;
            mv_seen = 1'b1;
            if (Wready) begin
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_result", 32'h1, 32'h0);
                end else begin
                    logic [32:0] e;
                    e = sbq.pop_front();
                    chk("ReadDataM", ReadDataM, e[31:0]);
                    chk("MemErrM", {31'h0, MemErrM}, {31'h0, e[32]});
                end
            end
        end
        mv_prev = resetn && Mvalid;
    end

    task automatic send(input logic rd, input logic wr, input logic [3:0] mask,
                        input logic [2:0] ropc, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_data,
                        input logic exp_err);
        bit done;
        done = 1'b0;
        @(negedge clk);
        MemReadM = rd; MemWriteM = wr; WmaskM = mask; RopcodeM = ropc;
        ALUResultM = addr; WriteDataM = wdata; in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (Mready) begin
                xfer_cyc = cyc;
                sbq.push_back({exp_err, exp_data});
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) chk("send_timeout", 32'h0, 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            #3;
            if (sbq.size() == 0 && Mready) done = 1'b1;
        end
        if (!done) chk("done_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        int g0;
        resetn = 1'b0; in_valid = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0;
        WmaskM = 4'h0; RopcodeM = 3'b000; ALUResultM = '0; WriteDataM = '0;
        Wready = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // reset state
        chk("rst_Mready",    {31'h0, Mready},   32'h1);
        chk("rst_Mvalid",    {31'h0, Mvalid},   32'h0);
        chk("rst_dreq",      {31'h0, dmem.dreq}, 32'h0);
        chk("rst_dwe",       {31'h0, dmem.dwe},  32'h0);
        chk("rst_MemErrM",   {31'h0, MemErrM},  32'h0);
        chk("rst_ReadDataM", ReadDataM,   32'h0);
        chk("rst_daddr",     dmem.daddr,  32'h0);
        chk("rst_dwdata",    dmem.dwdata, 32'h0);
        chk("rst_dwstrb",    {28'h0, dmem.dwstrb}, 32'h0);

        // LW, immediate grant, 1-cycle response: Mvalid 3 cycles after transfer
        cfg_rdata = 32'hDEADBEEF;
        send(1'b1, 1'b0, 4'h0, 3'b010, 32'h80000010, 32'h0, 32'hDEADBEEF, 1'b0);
        wait_done();
        chk("lw_daddr",   log_addr, 32'h80000010);
        chk("lw_dwe",     {31'h0, log_we}, 32'h0);
        chk("lw_latency", mvalid_cyc - xfer_cyc, 32'd3);

        // LB / LBU from the top lane
        cfg_rdata = 32'h80FF0000;
        send(1'b1, 1'b0, 4'h0, 3'b000, 32'h80000013, 32'h0, 32'hFFFFFF80, 1'b0);
        wait_done();
        send(1'b1, 1'b0, 4'h0, 3'b100, 32'h80000013, 32'h0, 32'h00000080, 1'b0);
        wait_done();
        // LHU / LW-by-unknown-opcode
        cfg_rdata = 32'h8001_7F02;
        send(1'b1, 1'b0, 4'h0, 3'b101, 32'h80000042, 32'h0, 32'h00008001, 1'b0);
        wait_done();
        send(1'b1, 1'b0, 4'h0, 3'b111, 32'h80000044, 32'h0, 32'h80017F02, 1'b0);
        wait_done();

        // SB into lane 2
        send(1'b0, 1'b1, 4'b0001, 3'b000, 32'h80000102, 32'h000000AB, 32'h0, 1'b0);
        wait_done();
        chk("sb_daddr",  log_addr, 32'h80000100);
        chk("sb_dwe",    {31'h0, log_we}, 32'h1);
        chk("sb_dwstrb", {28'h0, log_strb}, 32'h4);
        chk("sb_dwdata", log_wdata, 32'h00AB0000);

        // SH into upper half
        send(1'b0, 1'b1, 4'b0011, 3'b000, 32'h80000206, 32'h0000BEEF, 32'h0, 1'b0);
        wait_done();
        chk("sh_dwstrb", {28'h0, log_strb}, 32'hC);
        chk("sh_dwdata", log_wdata, 32'hBEEF0000);

        // Grant stalled 4 cycles, MEM/WB stalled 3 cycles in DONE
        cfg_gnt_wait = 4;
        cfg_rsp_wait = 1;
        cfg_rdata    = 32'h8001_0000;
        Wready       = 1'b0;
        send(1'b1, 1'b0, 4'h0, 3'b001, 32'h80000006, 32'h0, 32'hFFFF8001, 1'b0);
        for (int i = 0; i < 40 && !Mvalid; i++) @(negedge clk);
        in_valid = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("hold_Mvalid",    {31'h0, Mvalid}, 32'h1);
            chk("hold_ReadDataM", ReadDataM, 32'hFFFF8001);
            chk("hold_Mready",    {31'h0, Mready}, 32'h0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        Wready = 1'b1;
        wait_done();
        cfg_gnt_wait = 0;
        cfg_rsp_wait = 0;

        // Non-memory entry: result next cycle, zero data, no bus access
        g0 = n_grants;
        send(1'b0, 1'b0, 4'h0, 3'b000, 32'h12345678, 32'hFFFFFFFF, 32'h0, 1'b0);
        wait_done();
        chk("nonmem_latency", mvalid_cyc - xfer_cyc, 32'd1);
        chk("nonmem_no_req",  n_grants - g0, 32'd0);

        // Misaligned LW and SH: immediate error, no bus access
        send(1'b1, 1'b0, 4'h0, 3'b010, 32'h80000002, 32'h0, 32'h0, 1'b1);
        wait_done();
        chk("mis_lw_latency", mvalid_cyc - xfer_cyc, 32'd1);
        send(1'b0, 1'b1, 4'b0011, 3'b000, 32'h80000003, 32'h1234, 32'h0, 1'b1);
        wait_done();
        chk("mis_no_req", n_grants - g0, 32'd0);

        // Response error on a load
        cfg_rdata = 32'h0;
        cfg_derr  = 1'b1;
        send(1'b1, 1'b0, 4'h0, 3'b010, 32'h80000020, 32'h0, 32'h0, 1'b1);
        wait_done();
        cfg_derr  = 1'b0;

        // Reset while waiting for a response, then a late stray response
        cfg_rsp_wait = 5;
        cfg_rdata    = 32'hCAFEF00D;
        g0 = n_grants;
        send(1'b1, 1'b0, 4'h0, 3'b010, 32'h80000030, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 20 && n_grants == g0; i++) @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        sbq.delete();
        mv_seen   = 1'b0;
        stray_rsp = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_mid_Mready", {31'h0, Mready},    32'h1);
            chk("rst_mid_dreq",   {31'h0, dmem.dreq}, 32'h0);
        end
        chk("rst_mid_no_mvalid", {31'h0, mv_seen}, 32'h0);
        cfg_rsp_wait = 0;

        // Normal traffic resumes after the mid-op reset
        cfg_rdata = 32'h0000_7F00;
        send(1'b1, 1'b0, 4'h0, 3'b000, 32'h80000041, 32'h0, 32'h0000007F, 1'b0);
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Absolute watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
